// File: rtl/char_action_sequencer_pkg.sv
// char_action_sequencer_pkg: action state codes shared with the character position handler
package char_action_sequencer_pkg;
  localparam logic [3:0] S_IDLE                = 4'b0000;
  localparam logic [3:0] S_LEFT                = 4'b0001;
  localparam logic [3:0] S_RIGHT               = 4'b0010;
  localparam logic [3:0] S_ATTACK_START        = 4'b0011;
  localparam logic [3:0] S_ATTACK_ACTIVE       = 4'b0100;
  localparam logic [3:0] S_ATTACK_RECOVERY     = 4'b0101;
  localparam logic [3:0] S_ATTACK_DIR_START    = 4'b0110;
  localparam logic [3:0] S_ATTACK_DIR_ACTIVE   = 4'b0111;
  localparam logic [3:0] S_ATTACK_DIR_RECOVERY = 4'b1000;
  localparam int CNT_W = 5;
  typedef enum logic [3:0] {
    ST_IDLE                = S_IDLE,
    ST_LEFT                = S_LEFT,
    ST_RIGHT               = S_RIGHT,
    ST_ATTACK_START        = S_ATTACK_START,
    ST_ATTACK_ACTIVE       = S_ATTACK_ACTIVE,
    ST_ATTACK_RECOVERY     = S_ATTACK_RECOVERY,
    ST_ATTACK_DIR_START    = S_ATTACK_DIR_START,
    ST_ATTACK_DIR_ACTIVE   = S_ATTACK_DIR_ACTIVE,
    ST_ATTACK_DIR_RECOVERY = S_ATTACK_DIR_RECOVERY
  } state_e;
  function automatic logic is_busy(input logic [3:0] s);
    return s >= S_ATTACK_START && s <= S_ATTACK_DIR_RECOVERY;
  endfunction
endpackage

// File: rtl/char_action_sequencer_if.sv
// char_action_sequencer_if: frame tick, button levels and action state outputs of one player
interface char_action_sequencer_if;
  logic       frame_tick;
  logic       btn_left;
  logic       btn_right;
  logic       btn_attack;
  logic [3:0] state;
  logic       move_tick;
  logic       hitbox_active;
  logic       busy;
  modport master (output frame_tick, btn_left, btn_right, btn_attack,
                  input state, move_tick, hitbox_active, busy);
  modport slave  (input frame_tick, btn_left, btn_right, btn_attack,
                  output state, move_tick, hitbox_active, busy);
endinterface

// File: rtl/char_action_sequencer_frame_phase_counter.sv
// frame_phase_counter: loadable frame down-counter, flags zero so a phase can advance on the next tick
module frame_phase_counter
  import char_action_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (tick_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/char_action_sequencer.sv
// char_action_sequencer: per-player idle/walk/attack FSM advancing on frame ticks.
// ATTACK_BUFFER_EN: attack presses during recovery chain straight into the next attack.
module char_action_sequencer
  import char_action_sequencer_pkg::*;
#(
  parameter int START_FRAMES        = 5,
  parameter int ACTIVE_FRAMES       = 2,
  parameter int RECOVERY_FRAMES     = 16,
  parameter int DIR_START_FRAMES    = 4,
  parameter int DIR_ACTIVE_FRAMES   = 3,
  parameter int DIR_RECOVERY_FRAMES = 15
) (
  input logic clk,
  input logic rst,
  char_action_sequencer_if.slave bus
);
`ifdef ATTACK_BUFFER_EN
  localparam logic BUF = 1'b1;
`else
  localparam logic BUF = 1'b0;
`endif
  state_e           state_q, state_d, atk_st, walk, rec_exit;
  logic             pending_q, pending_d, atk_q, move_q, pend, zero, load, keep, take;
  logic [CNT_W-1:0] load_val;
  always_comb begin
    pend     = pending_q | (bus.btn_attack & ~atk_q);
    atk_st   = (bus.btn_left ^ bus.btn_right) ? ST_ATTACK_DIR_START : ST_ATTACK_START;
    walk     = (bus.btn_left & ~bus.btn_right) ? ST_LEFT :
               (bus.btn_right & ~bus.btn_left) ? ST_RIGHT : ST_IDLE;
    rec_exit = (BUF && pend) ? atk_st : ST_IDLE;
    state_d  = state_q;
    if (bus.frame_tick)
      case (state_q)
        ST_IDLE, ST_LEFT, ST_RIGHT: state_d = pend ? atk_st : walk;
        ST_ATTACK_START:            state_d = zero ? ST_ATTACK_ACTIVE : state_q;
        ST_ATTACK_ACTIVE:           state_d = zero ? ST_ATTACK_RECOVERY : state_q;
        ST_ATTACK_RECOVERY:         state_d = zero ? rec_exit : state_q;
        ST_ATTACK_DIR_START:        state_d = zero ? ST_ATTACK_DIR_ACTIVE : state_q;
        ST_ATTACK_DIR_ACTIVE:       state_d = zero ? ST_ATTACK_DIR_RECOVERY : state_q;
        ST_ATTACK_DIR_RECOVERY:     state_d = zero ? rec_exit : state_q;
        default:                    state_d = ST_IDLE;
      endcase
    // presses are only remembered outside attacks, or during recovery when buffering
    keep      = !is_busy(state_q) ||
                (BUF && (state_q == ST_ATTACK_RECOVERY || state_q == ST_ATTACK_DIR_RECOVERY));
    take      = bus.frame_tick && (state_d == ST_ATTACK_START || state_d == ST_ATTACK_DIR_START);
    pending_d = keep & ~take & pend;
    load      = bus.frame_tick && state_d != state_q;
    load_val  = state_d == ST_ATTACK_START        ? CNT_W'(START_FRAMES - 1) :
                state_d == ST_ATTACK_ACTIVE       ? CNT_W'(ACTIVE_FRAMES - 1) :
                state_d == ST_ATTACK_RECOVERY     ? CNT_W'(RECOVERY_FRAMES - 1) :
                state_d == ST_ATTACK_DIR_START    ? CNT_W'(DIR_START_FRAMES - 1) :
                state_d == ST_ATTACK_DIR_ACTIVE   ? CNT_W'(DIR_ACTIVE_FRAMES - 1) :
                state_d == ST_ATTACK_DIR_RECOVERY ? CNT_W'(DIR_RECOVERY_FRAMES - 1) : '0;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      atk_q     <= 1'b0;
      move_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      atk_q     <= bus.btn_attack;
      move_q    <= bus.frame_tick;
    end
  frame_phase_counter u_cnt (
    .clk        (clk),
    .rst        (rst),
    .tick_i     (bus.frame_tick),
    .load_i     (load),
    .load_val_i (load_val),
    .zero_o     (zero)
  );
  assign bus.state         = state_q;
  assign bus.move_tick     = move_q;
  assign bus.hitbox_active = state_q == ST_ATTACK_ACTIVE || state_q == ST_ATTACK_DIR_ACTIVE;
  assign bus.busy          = is_busy(state_q);
endmodule

// File: tb/tb_char_action_sequencer.sv
// tb_char_action_sequencer: scoreboard bench; expected post-tick states are queued then checked per tick
module tb_char_action_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [3:0] exp_q[$];
  char_action_sequencer_if f();
  char_action_sequencer dut (.clk(clk), .rst(rst), .bus(f));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic push(input logic [3:0] s, input int n);
    repeat (n) exp_q.push_back(s);
  endtask
  task automatic tick(input bit atk);
    logic [3:0] e;
    @(negedge clk);
    f.frame_tick = 1'b1;
    if (atk) f.btn_attack = 1'b1;
    @(posedge clk);
    #1;
    f.frame_tick = 1'b0;
    if (exp_q.size() == 0) check("queue_empty", 1, 0);
    else begin
      e = exp_q.pop_front();
      check("state", {28'd0, f.state}, {28'd0, e});
      check("busy", {31'd0, f.busy}, {31'd0, e >= 4'd3 && e <= 4'd8});
      check("hitbox", {31'd0, f.hitbox_active}, {31'd0, e == 4'd4 || e == 4'd7});
    end
    check("move_tick", {31'd0, f.move_tick}, 1);
  endtask
  task automatic drain();
    while (exp_q.size() != 0) tick(1'b0);
  endtask
  task automatic press();
    @(negedge clk) f.btn_attack = 1'b1;
    @(negedge clk);
    @(negedge clk) f.btn_attack = 1'b0;
  endtask
  task automatic reset_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0;
      {f.frame_tick, f.btn_left, f.btn_right, f.btn_attack} = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      check("rst_state", {28'd0, f.state}, 0);
      check("rst_move", {31'd0, f.move_tick}, 0);
      check("rst_busy", {31'd0, f.busy}, 0);
    end
    @(negedge clk);
    {f.frame_tick, f.btn_left, f.btn_right, f.btn_attack} = 4'd0;
    rst = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  initial begin
    {f.frame_tick, f.btn_left, f.btn_right, f.btn_attack} = 4'd0;
    reset_pulse(3);
    @(negedge clk) f.btn_left = 1'b1;
    push(4'd1, 1);
    drain();
    @(posedge clk);
    #1;
    check("move_pulse_end", {31'd0, f.move_tick}, 0);
    @(negedge clk) f.btn_right = 1'b1;
    push(4'd0, 1);
    drain();
    @(negedge clk) f.btn_left = 1'b0;
    push(4'd2, 1);
    drain();
    @(negedge clk) f.btn_right = 1'b0;
    push(4'd0, 1);
    drain();
    press();
    push(4'd3, 5); push(4'd4, 2); push(4'd5, 16); push(4'd0, 1);
    drain();
    @(negedge clk) f.btn_right = 1'b1;
    push(4'd6, 4); push(4'd7, 3); push(4'd8, 15); push(4'd0, 1); push(4'd2, 1);
    tick(1'b1);
    drain();
    @(negedge clk) {f.btn_right, f.btn_attack} = 2'b00;
    push(4'd0, 1);
    drain();
    press();
    push(4'd3, 5); push(4'd4, 1);
    drain();
    press();
    push(4'd4, 1); push(4'd5, 1);
    drain();
    press();
`ifdef ATTACK_BUFFER_EN
    push(4'd5, 15); push(4'd3, 1);
    drain();
    reset_pulse(1);
`else
    push(4'd5, 15); push(4'd0, 1);
    drain();
`endif
    push(4'd0, 1);
    drain();
    press();
    push(4'd3, 5); push(4'd4, 1);
    drain();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_state", {28'd0, f.state}, 0);
    check("mid_rst_busy", {31'd0, f.busy}, 0);
    check("mid_rst_hitbox", {31'd0, f.hitbox_active}, 0);
    @(negedge clk) rst = 1'b1;
    push(4'd0, 2);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
